// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states and
// the byte-lane helpers used by both the request decoder and the load aligner.
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } lsu_state_e;

  // funct3[1:0] encodes access size for every legal code: 00 byte, 01 half, 10 word.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b00:   lane_mask = 4'b0001 << offset;
      2'b01:   lane_mask = offset[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_illegal(input logic write, input logic [2:0] funct3);
    if (write)
      is_illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
    else
      is_illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b01:   is_misaligned = offset[0];
      2'b10:   is_misaligned = (offset != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_aligner.sv
// Combinational load extraction: picks the addressed byte/half from a memory word
// and sign- or zero-extends it according to funct3.
module load_aligner
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = rdata[{offset, 3'b000} +: 8];
    half_s = offset[1] ? rdata[31:16] : rdata[15:0];
    result = '0;
    case (funct3)
      F3_LB:   result = 32'(byte_s);
      F3_LH:   result = 32'(half_s);
      F3_LW:   result = rdata;
      F3_LBU:  result = {24'd0, byte_s};
      F3_LHU:  result = {16'd0, half_s};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a registered-read data memory: decodes and
// checks requests, drives byte-lane writes, and returns extended load data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_misaligned,
  output logic                  resp_illegal,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic [3:0]            mem_write_mask,
  input  logic [31:0]           mem_read_data
);

  lsu_state_e  state, state_next;
  logic        accept_p0, illegal_p0, misaligned_p0, fault_p0;
  logic [2:0]  funct3_p1;
  logic [1:0]  offset_p1;
  logic [31:0] aligned_p1;
  logic        unused_addr;

  // Addresses wrap within the memory window; upper bits are deliberately dropped.
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  // Stage p0: decode the request presented in IDLE and drive the memory directly.
  always_comb begin
    req_ready        = reset_n && (state == ST_IDLE);
    accept_p0        = req_valid && req_ready;
    illegal_p0       = is_illegal(req_write, req_funct3);
    misaligned_p0    = !illegal_p0 && is_misaligned(req_funct3, req_addr[1:0]);
    fault_p0         = illegal_p0 || misaligned_p0;
    mem_read_enable  = accept_p0 && !req_write && !fault_p0;
    mem_write_enable = accept_p0 &&  req_write && !fault_p0;
    mem_address      = req_addr[ADDR_WIDTH+1:2];
    mem_write_mask   = lane_mask(req_funct3, req_addr[1:0]);
    case (req_funct3[1:0])
      2'b00:   mem_write_data = {4{req_wdata[7:0]}};
      2'b01:   mem_write_data = {2{req_wdata[15:0]}};
      default: mem_write_data = req_wdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (mem_read_enable) state_next = ST_LOAD_WAIT;
      ST_LOAD_WAIT: state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept_p0) begin
      funct3_p1 <= req_funct3;
      offset_p1 <= req_addr[1:0];
    end
  end

  // Stage p1: memory word arrives; extract and extend it.
  load_aligner u_load_aligner (
    .rdata  (mem_read_data),
    .offset (offset_p1),
    .funct3 (funct3_p1),
    .result (aligned_p1)
  );

  // Stage p2: registered response. Stores and faults answer one cycle after accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      resp_valid      <= 1'b0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      resp_rdata      <= '0;
    end else begin
      state           <= state_next;
      resp_valid      <= (accept_p0 && (req_write || fault_p0)) || (state == ST_LOAD_WAIT);
      resp_misaligned <= accept_p0 && misaligned_p0;
      resp_illegal    <= accept_p0 && illegal_p0;
      resp_rdata      <= (state == ST_LOAD_WAIT) ? aligned_p1 : '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed spec cases plus randomized requests checked
// against a byte-level reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned, resp_illegal;
  logic [31:0] resp_rdata;
  logic        mem_read_enable, mem_write_enable;
  logic [9:0]  mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_mask;
  logic [31:0] mem_read_data;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_mask(mem_write_mask), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h8899_AABB;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Memory device: registered read, byte-masked write.
  logic [31:0] mem [0:1023];
  logic        init_go = 1'b0;
  int          en_count = 0;

  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else begin
      if (mem_write_enable)
        for (int b = 0; b < 4; b++)
          if (mem_write_mask[b]) mem[mem_address][8*b +: 8] <= mem_write_data[8*b +: 8];
      if (mem_read_enable) mem_read_data <= mem[mem_address];
    end
    if (mem_read_enable || mem_write_enable) en_count <= en_count + 1;
  end

  logic [31:0] ref_mem [0:1023];

  task automatic init_mem();
    init_go = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    @(posedge clk); #1;
    init_go = 1'b0;
  endtask

  // Observations of one isolated transaction.
  logic        o_ready, o_ren, o_wen, o_mis, o_ill;
  logic [9:0]  o_addr;
  logic [31:0] o_wdata, o_rdata;
  logic [3:0]  o_mask;
  int          o_lat, o_pulses, o_en;

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    int en0;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    o_ready = req_ready; o_ren = mem_read_enable; o_wen = mem_write_enable;
    o_addr = mem_address; o_wdata = mem_write_data; o_mask = mem_write_mask;
    en0 = en_count;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    o_lat = -1; o_pulses = 0; o_rdata = 'x; o_mis = 1'bx; o_ill = 1'bx;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        o_pulses++;
        if (o_lat < 0) begin
          o_lat = k; o_rdata = resp_rdata; o_mis = resp_misaligned; o_ill = resp_illegal;
        end
      end
    end
    o_en = en_count - en0;
    @(posedge clk); #1;
  endtask

  // Reference model: expectations from RV32I access rules on a byte-addressed memory.
  logic        e_ren, e_wen, e_mis, e_ill;
  logic [9:0]  e_addr;
  logic [31:0] e_wdata, e_rdata;
  logic [3:0]  e_mask;
  int          e_lat;

  task automatic model_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    int off, idx, size;
    longint v;
    logic [31:0] word, bm;
    off  = int'(a[1:0]);
    idx  = int'(a[11:2]);
    size = 1 << int'(f3[1:0]);
    e_ill = w ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e_mis = !e_ill && ((off % size) != 0);
    e_addr = a[11:2];
    e_ren = !w && !e_ill && !e_mis;
    e_wen =  w && !e_ill && !e_mis;
    e_rdata = '0; e_mask = '0; e_wdata = '0; e_lat = 1;
    word = ref_mem[idx];
    if (e_ren) begin
      e_lat = 2;
      if (size == 4) e_rdata = word;
      else begin
        v = longint'((word >> (8 * off)) & ((size == 1) ? 32'hFF : 32'hFFFF));
        if (!f3[2] && size == 1 && v > 127)   v = v - 256;
        if (!f3[2] && size == 2 && v > 32767) v = v - 65536;
        e_rdata = 32'(v);
      end
    end
    if (e_wen) begin
      e_wdata = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
      e_mask = 4'(((1 << size) - 1) << off);
      for (int b = 0; b < 4; b++) bm[8*b +: 8] = e_mask[b] ? 8'hFF : 8'h00;
      ref_mem[idx] = (word & ~bm) | (e_wdata & bm);
    end
  endtask

  task automatic test_reset();
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = '0;
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", req_ready); end
    n_tests++; if ({mem_read_enable, mem_write_enable} !== 2'b00) begin n_fail++; $display("FAIL reset_enables got %b want 00", {mem_read_enable, mem_write_enable}); end
    n_tests++; if ({resp_valid, resp_misaligned, resp_illegal} !== 3'b000) begin n_fail++; $display("FAIL reset_resp_flags got %b want 000", {resp_valid, resp_misaligned, resp_illegal}); end
    n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    @(posedge clk); #1;
    req_valid = 1'b0; reset_n = 1'b1;
    init_mem();
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %b want 1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd0};
    logic [31:0] adr [6] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h10, 32'h10};
    logic [31:0] exp [6] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_AABB, 32'h0000_8899, 32'h8899_AABB, 32'hFFFF_FFBB};
    init_mem();
    for (int i = 0; i < 6; i++) begin
      run_req(1'b0, f3s[i], adr[i], 32'h0);
      n_tests++; if ({o_ready, o_ren, o_wen} !== 3'b110) begin n_fail++; $display("FAIL load%0d_accept got %b want 110", i, {o_ready, o_ren, o_wen}); end
      n_tests++; if (o_addr !== 10'd4) begin n_fail++; $display("FAIL load%0d_addr got %0d want 4", i, o_addr); end
      n_tests++; if (o_lat !== 2 || o_pulses !== 1) begin n_fail++; $display("FAIL load%0d_latency got %0d/%0d want 2/1", i, o_lat, o_pulses); end
      n_tests++; if (o_rdata !== exp[i]) begin n_fail++; $display("FAIL load%0d_rdata got %h want %h", i, o_rdata, exp[i]); end
      n_tests++; if ({o_mis, o_ill} !== 2'b00) begin n_fail++; $display("FAIL load%0d_flags got %b want 00", i, {o_mis, o_ill}); end
    end
  endtask

  task automatic test_stores();
    init_mem();
    run_req(1'b1, 3'd0, 32'h11, 32'h0000_0055);
    n_tests++; if ({o_ren, o_wen, o_mask} !== 6'b01_0010) begin n_fail++; $display("FAIL sb_en_mask got %b want 010010", {o_ren, o_wen, o_mask}); end
    n_tests++; if (o_wdata !== 32'h5555_5555) begin n_fail++; $display("FAIL sb_wdata got %h want 55555555", o_wdata); end
    n_tests++; if (o_lat !== 1 || o_rdata !== 32'h0) begin n_fail++; $display("FAIL sb_resp got lat %0d rdata %h want 1/0", o_lat, o_rdata); end
    n_tests++; if (mem[4] !== 32'h8899_55BB) begin n_fail++; $display("FAIL sb_word got %h want 889955bb", mem[4]); end
    run_req(1'b1, 3'd1, 32'h12, 32'h0000_1234);
    n_tests++; if ({o_wen, o_mask} !== 5'b1_1100) begin n_fail++; $display("FAIL sh_en_mask got %b want 11100", {o_wen, o_mask}); end
    n_tests++; if (o_wdata !== 32'h1234_1234) begin n_fail++; $display("FAIL sh_wdata got %h want 12341234", o_wdata); end
    n_tests++; if (mem[4] !== 32'h1234_55BB) begin n_fail++; $display("FAIL sh_word got %h want 123455bb", mem[4]); end
    run_req(1'b0, 3'd2, 32'h10, 32'h0);
    n_tests++; if (o_rdata !== 32'h1234_55BB) begin n_fail++; $display("FAIL store_lw_rdata got %h want 123455bb", o_rdata); end
    run_req(1'b1, 3'd2, 32'h10, 32'hCAFE_F00D);
    n_tests++; if ({o_wen, o_mask} !== 5'b1_1111 || o_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL sw_drive got %b %h want 11111 cafef00d", {o_wen, o_mask}, o_wdata); end
  endtask

  task automatic test_faults();
    logic        ws  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s [5] = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd6};
    logic [31:0] adr [5] = '{32'h12, 32'h11, 32'h10, 32'h10, 32'h13};
    logic [1:0]  flg [5] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
    init_mem();
    for (int i = 0; i < 5; i++) begin
      run_req(ws[i], f3s[i], adr[i], 32'hDEAD_BEEF);
      n_tests++; if (o_ready !== 1'b1 || o_en !== 0) begin n_fail++; $display("FAIL fault%0d_no_access got ready %b enables %0d want 1/0", i, o_ready, o_en); end
      n_tests++; if (o_lat !== 1 || o_pulses !== 1) begin n_fail++; $display("FAIL fault%0d_latency got %0d/%0d want 1/1", i, o_lat, o_pulses); end
      n_tests++; if ({o_mis, o_ill} !== flg[i]) begin n_fail++; $display("FAIL fault%0d_flags got %b want %b", i, {o_mis, o_ill}, flg[i]); end
      n_tests++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL fault%0d_rdata got %h want 0", i, o_rdata); end
    end
    n_tests++; if (mem[4] !== 32'h8899_AABB) begin n_fail++; $display("FAIL fault_word got %h want 8899aabb", mem[4]); end
  endtask

  task automatic test_back_to_back();
    logic rv [5];
    init_mem();
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h20 + 32'(4 * c); req_wdata = 32'hA000_0000 + 32'(c);
      end else req_valid = 1'b0;
      @(negedge clk);
      rv[c] = resp_valid;
      if (c < 3) begin
        n_tests++; if ({req_ready, mem_write_enable} !== 2'b11) begin n_fail++; $display("FAIL b2b_accept%0d got %b want 11", c, {req_ready, mem_write_enable}); end
      end
      @(posedge clk); #1;
    end
    n_tests++; if ({rv[0], rv[1], rv[2], rv[3], rv[4]} !== 5'b01110) begin n_fail++; $display("FAIL b2b_resp_pattern got %b want 01110", {rv[0], rv[1], rv[2], rv[3], rv[4]}); end
    for (int c = 0; c < 3; c++) begin
      n_tests++; if (mem[8 + c] !== 32'hA000_0000 + 32'(c)) begin n_fail++; $display("FAIL b2b_word%0d got %h want %h", c, mem[8 + c], 32'hA000_0000 + 32'(c)); end
    end
  endtask

  task automatic test_handshake();
    logic [31:0] got1;
    init_mem();
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(negedge clk);
    n_tests++; if ({req_ready, mem_read_enable} !== 2'b11) begin n_fail++; $display("FAIL hs_first_accept got %b want 11", {req_ready, mem_read_enable}); end
    @(posedge clk); #1;
    req_addr = 32'h210;
    @(negedge clk);
    n_tests++; if ({req_ready, mem_read_enable, resp_valid} !== 3'b000) begin n_fail++; $display("FAIL hs_stall got %b want 000", {req_ready, mem_read_enable, resp_valid}); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if ({req_ready, mem_read_enable, resp_valid} !== 3'b111) begin n_fail++; $display("FAIL hs_second_accept got %b want 111", {req_ready, mem_read_enable, resp_valid}); end
    got1 = resp_rdata;
    n_tests++; if (got1 !== 32'h8899_AABB) begin n_fail++; $display("FAIL hs_first_rdata got %h want 8899aabb", got1); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL hs_gap got %b want 0", resp_valid); end
    @(negedge clk);
    n_tests++; if (resp_valid !== 1'b1 || resp_rdata !== init_word(32'h84)) begin n_fail++; $display("FAIL hs_second_resp got %b %h want 1 %h", resp_valid, resp_rdata, init_word(32'h84)); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load();
    init_mem();
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b1; reset_n = 1'b0;
    @(negedge clk);
    n_tests++; if ({req_ready, mem_read_enable, mem_write_enable} !== 3'b000) begin n_fail++; $display("FAIL rst_hold_outputs got %b want 000", {req_ready, mem_read_enable, mem_write_enable}); end
    @(posedge clk); #1;
    req_valid = 1'b0; reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++; if ({resp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_dropped%0d got %b want 01", k, {resp_valid, req_ready}); end
    end
    @(posedge clk); #1;
    run_req(1'b0, 3'd2, 32'h10, 32'h0);
    n_tests++; if (o_lat !== 2 || o_rdata !== 32'h8899_AABB) begin n_fail++; $display("FAIL rst_next_load got lat %0d rdata %h want 2 8899aabb", o_lat, o_rdata); end
  endtask

  task automatic test_random();
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    int          idx, bad;
    init_mem();
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? $urandom : (32'h10 + 32'($urandom_range(0, 15)));
      wd = $urandom;
      idx = int'(a[11:2]);
      model_req(w, f3, a, wd);
      run_req(w, f3, a, wd);
      n_tests++;
      if (o_ready !== 1'b1 || o_ren !== e_ren || o_wen !== e_wen || o_lat !== e_lat || o_pulses !== 1 ||
          o_rdata !== e_rdata || o_mis !== e_mis || o_ill !== e_ill ||
          ((e_ren || e_wen) && o_addr !== e_addr) || (e_wen && (o_mask !== e_mask || o_wdata !== e_wdata)) ||
          mem[idx] !== ref_mem[idx]) begin
        n_fail++; bad++;
        if (bad < 6)
          $display("FAIL rand%0d w%b f3=%0d a=%h got ren%b wen%b lat%0d rd=%h mis%b ill%b mask%b wd=%h mem=%h want ren%b wen%b lat%0d rd=%h mis%b ill%b mask%b wd=%h mem=%h",
                   i, w, f3, a, o_ren, o_wen, o_lat, o_rdata, o_mis, o_ill, o_mask, o_wdata, mem[idx],
                   e_ren, e_wen, e_lat, e_rdata, e_mis, e_ill, e_mask, e_wdata, ref_mem[idx]);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_back_to_back();
    test_handshake();
    test_reset_mid_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
